pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-type inter-stage register.
- Generic pipeline stage register with valid/ready handshake, flush, optional two-entry skid buffer, and a saturating back-pressure counter.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the payload is an opaque WIDTH-bit packed struct.
- Replaces the bare stall-hold scheme with lossless back-pressure, so ready can be registered for timing closure.

Parameters:
- WIDTH, 64, payload width in bits (≥1).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready.
- CNT_W, 16, width of the stall counter (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries (branch mispredict/exception).
- in_valid  in  1  upstream has payload.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to downstream.
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.
- occupancy  out  2  number of held entries (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - Evaluated on the rising clk edge.
- Reset: out_valid=0, out_data='0, skid entry invalid with data '0, stall_cnt=0, occupancy=0.
  - in_ready=1 in the cycle after reset (SKID=1).
  - For SKID=0, in_ready follows the combinational rule below.
- Reset overrides flush and any handshake. Asserting reset mid-transfer drops all entries; nothing is emitted afterwards.
- out_data is driven only from the main register. The skid register is never visible at the output.
- Latency: one cycle from accept to out_valid when the stage is empty. Zero-bubble throughput of 1 item/cycle while out_ready=1.
- SKID=1 states (occupancy encodes the state):
  - EMPTY (0): in_ready=1.
    - Accept → FULL; main ← in_data.
  - FULL (1): in_ready=1.
    - Accept & Emit → FULL; main ← in_data.
    - Accept & !Emit → SKID; skid ← in_data.
    - !Accept & Emit → EMPTY.
    - Otherwise hold.
  - SKID (2): in_ready=0, registered (depends only on state).
    - Emit → FULL; main ← skid.
    - Otherwise hold. An in_valid arriving in SKID is not accepted; upstream must hold it.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept loads main.
  - Emit without accept clears out_valid.
  - Occupancy ∈ {0,1}.
- Flush:
  - In the flush cycle, any handshake is ignored for state purposes. An accept in that cycle is discarded; an emit still counts downstream (downstream owns its own flush).
  - Next cycle: EMPTY, out_valid=0, in_ready=1 (SKID=1).
  - Data registers keep their stale value; no zeroing required.
- Payload integrity: items leave in the order accepted. No duplication; no loss except via flush or reset.
- stall_cnt:
  - +1 on every cycle with out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W−1; no wrap.
  - Cleared only by reset; unaffected by flush.
- out_ready is allowed to toggle freely. in_valid deassertion without accept is legal (no valid-stickiness checking).

Test Plan:
- Streaming, WIDTH=64, SKID=1: in_valid=1 with data 1,2,3,…,10 on consecutive cycles, out_ready=1 → out_data 1..10 on cycles 1..10 after the first accept; occupancy stays 1; stall_cnt=0.
- Back-pressure: send A=0xAA, then B=0xBB; drop out_ready the cycle A is presented → B goes to skid, occupancy=2, in_ready=0 next cycle; C=0xCC held by upstream. Raise out_ready → A, B, C emerge in order; stall_cnt=1.
- Flush in SKID state (A in main, B in skid) with in_valid=1 and data 0xDD → next cycle out_valid=0, occupancy=0, in_ready=1; 0xDD is never emitted.
- Saturation, CNT_W=4: hold out_valid with out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays 15.
- SKID=0: out_ready=0 with an item held → in_ready=0 in the same cycle. out_ready=1 with in_valid=1 → accept and emit in the same cycle; occupancy=1.
- Reset mid-operation: assert reset while occupancy=2 and stall_cnt=7 → next cycle all outputs at reset values; the held items never appear on out_data.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, flush, an optional
// two-entry skid buffer and a saturating back-pressure counter.
// The payload is opaque; out_data always comes from the main register.
module pipe_stage_skid_reg #(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       occupancy
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_emit;

    assign w_accept  = in_valid & w_in_ready;
    assign w_emit    = r_main_valid & out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

    generate
        if (SKID != 0) begin : g_skid
            // Second entry absorbs the one item that can arrive while
            // in_ready is being withdrawn, so in_ready can be a pure register.
            logic             r_skid_valid;
            logic [WIDTH-1:0] r_skid_data;

            // in_ready depends only on state: closed while the skid entry is held
            assign w_in_ready = ~r_skid_valid;
            // The skid entry is only ever valid behind a valid main entry
            assign occupancy  = {r_skid_valid, r_main_valid & ~r_skid_valid};

            // Entry-valid tracking: EMPTY / FULL / SKID transitions
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (r_skid_valid) begin
                    if (w_emit) begin
                        r_skid_valid <= 1'b0;
                    end
                end else if (r_main_valid) begin
                    if (w_accept && !w_emit) begin
                        r_skid_valid <= 1'b1;
                    end else if (!w_accept && w_emit) begin
                        r_main_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_main_valid <= 1'b1;
                end
            end

            // Payload movement; a flush leaves stale data in place
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_main_data <= '0;
                    r_skid_data <= '0;
                end else if (!flush) begin
                    if (r_skid_valid) begin
                        if (w_emit) begin
                            r_main_data <= r_skid_data;
                        end
                    end else if (w_accept) begin
                        if (r_main_valid && !w_emit) begin
                            r_skid_data <= in_data;
                        end else begin
                            r_main_data <= in_data;
                        end
                    end
                end
            end
        end else begin : g_single
            // Single entry: ready passes back combinationally from downstream
            assign w_in_ready = ~r_main_valid | out_ready;
            assign occupancy  = {1'b0, r_main_valid};

            // Main entry valid: set on accept, cleared on emit without accept
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_main_valid <= 1'b0;
                end else if (flush) begin
                    r_main_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main_valid <= 1'b1;
                end else if (w_emit) begin
                    r_main_valid <= 1'b0;
                end
            end

            // Main payload load on accept
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_main_data <= '0;
                end else if (!flush && w_accept) begin
                    r_main_data <= in_data;
                end
            end
        end
    endgenerate

    // Count back-pressured cycles, holding at all-ones; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: instance 0 uses SKID=1/CNT_W=16, instance 1
// uses SKID=0/CNT_W=4. Accepted items are queued as expected output and
// popped by a monitor on every emit; an occupancy-level model checks
// ready/valid/occupancy/stall_cnt every cycle.
`timescale 1ns/1ps
module tb_pipe_stage_skid_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        dv_flush     [2];
    logic        dv_in_valid  [2];
    logic        dv_out_ready [2];
    logic [63:0] dv_in_data   [2];
    logic        w_in_ready   [2];
    logic        w_out_valid  [2];
    logic [63:0] w_out_data   [2];
    logic [1:0]  w_occ        [2];
    logic [15:0] w_stall      [2];

    int   checks   = 0;
    int   failures = 0;
    logic do_final = 1'b0;

    function automatic void check(input string name, input int d,
                                  input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h expected=%0h", name, d, got, exp);
        end
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_dut
            localparam int     SK   = (gi == 0) ? 1 : 0;
            localparam int     CW   = (gi == 0) ? 16 : 4;
            localparam longint MAXC = (64'd1 << CW) - 64'd1;

            logic [CW-1:0] stall_local;

            pipe_stage_skid_reg #(.WIDTH(64), .SKID(SK), .CNT_W(CW)) u_dut (
                .clk       (clk),
                .reset     (reset),
                .flush     (dv_flush[gi]),
                .in_valid  (dv_in_valid[gi]),
                .in_ready  (w_in_ready[gi]),
                .in_data   (dv_in_data[gi]),
                .out_valid (w_out_valid[gi]),
                .out_ready (dv_out_ready[gi]),
                .out_data  (w_out_data[gi]),
                .stall_cnt (stall_local),
                .occupancy (w_occ[gi])
            );
            assign w_stall[gi] = 16'(stall_local);

            logic [63:0] exp_q[$];
            int     m_occ      = 0;
            longint m_cnt      = 0;
            bit     m_init     = 1'b0;
            bit     m_rst_seen = 1'b0;

            // Stimulus side: every accepted (non-flushed) item becomes an expectation
            always @(negedge clk) begin
                if (!reset && !dv_flush[gi] && dv_in_valid[gi] && w_in_ready[gi])
                    exp_q.push_back(dv_in_data[gi]);
            end

            // Monitor: compare emitted data and per-cycle status, then advance model
            always @(negedge clk) begin : mon
                bit m_ready;
                bit m_emit;
                bit m_acc;
                m_ready = (SK != 0) ? (m_occ < 2) : ((m_occ == 0) || (dv_out_ready[gi] == 1'b1));
                if (m_init) begin
                    check("occupancy", gi, 64'(w_occ[gi]), 64'(m_occ));
                    check("out_valid", gi, 64'(w_out_valid[gi]), 64'(m_occ > 0));
                    check("in_ready", gi, 64'(w_in_ready[gi]), 64'(m_ready));
                    check("stall_cnt", gi, 64'(w_stall[gi]), 64'(m_cnt));
                    if (m_rst_seen)
                        check("reset_out_data", gi, w_out_data[gi], 64'd0);
                    if (w_out_valid[gi] && dv_out_ready[gi]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_emit dut%0d got=%0h expected=none",
                                     gi, w_out_data[gi]);
                        end else begin
                            check("out_data", gi, w_out_data[gi], exp_q.pop_front());
                        end
                    end
                end
                if (do_final)
                    check("drain_empty", gi, 64'(exp_q.size()), 64'd0);
                if (reset) begin
                    m_occ      = 0;
                    m_cnt      = 0;
                    exp_q.delete();
                    m_init     = 1'b1;
                    m_rst_seen = 1'b1;
                end else begin
                    m_rst_seen = 1'b0;
                    m_emit = (m_occ > 0) && (dv_out_ready[gi] == 1'b1);
                    m_acc  = (dv_in_valid[gi] == 1'b1) && m_ready;
                    if ((m_occ > 0) && !dv_out_ready[gi] && !dv_flush[gi] && (m_cnt < MAXC))
                        m_cnt++;
                    if (dv_flush[gi]) begin
                        m_occ = 0;
                        exp_q.delete();
                    end else begin
                        m_occ = m_occ - int'(m_emit) + int'(m_acc);
                    end
                end
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        dv_in_valid[d]  = 1'b0;
        dv_in_data[d]   = '0;
        dv_out_ready[d] = 1'b1;
        dv_flush[d]     = 1'b0;
    endtask

    task automatic offer(input int d, input logic [63:0] data, input logic rdy);
        dv_in_valid[d]  = 1'b1;
        dv_in_data[d]   = data;
        dv_out_ready[d] = rdy;
    endtask

    bit acc [2];

    initial begin
        reset = 1'b1;
        idle(0);
        idle(1);
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 0, 64'(w_in_ready[0]), 64'd1);
        check("rst_out_valid", 0, 64'(w_out_valid[0]), 64'd0);
        check("rst_occ", 0, 64'(w_occ[0]), 64'd0);
        check("rst_stall", 0, 64'(w_stall[0]), 64'd0);
        check("rst_data", 0, w_out_data[0], 64'd0);
        step();

        // Back-pressure into the skid entry: A, B, then C held upstream
        offer(0, 64'hAA, 1'b1);
        step();
        offer(0, 64'hBB, 1'b0);
        step();
        offer(0, 64'hCC, 1'b1);
        @(negedge clk);
        check("bp_occ2", 0, 64'(w_occ[0]), 64'd2);
        check("bp_in_ready0", 0, 64'(w_in_ready[0]), 64'd0);
        check("bp_data_a", 0, w_out_data[0], 64'hAA);
        step();
        @(negedge clk);
        check("bp_in_ready1", 0, 64'(w_in_ready[0]), 64'd1);
        check("bp_data_b", 0, w_out_data[0], 64'hBB);
        step();
        dv_in_valid[0] = 1'b0;
        @(negedge clk);
        check("bp_data_c", 0, w_out_data[0], 64'hCC);
        step();
        @(negedge clk);
        check("bp_drained", 0, 64'(w_out_valid[0]), 64'd0);
        check("bp_stall1", 0, 64'(w_stall[0]), 64'd1);
        step();

        // Flush while in SKID state with a new offer pending
        offer(0, 64'hA1, 1'b1);
        step();
        offer(0, 64'hB1, 1'b0);
        step();
        offer(0, 64'hDD, 1'b0);
        dv_flush[0] = 1'b1;
        @(negedge clk);
        check("fl_occ2", 0, 64'(w_occ[0]), 64'd2);
        step();
        idle(0);
        @(negedge clk);
        check("fl_out_valid", 0, 64'(w_out_valid[0]), 64'd0);
        check("fl_occ0", 0, 64'(w_occ[0]), 64'd0);
        check("fl_in_ready", 0, 64'(w_in_ready[0]), 64'd1);
        check("fl_stall2", 0, 64'(w_stall[0]), 64'd2);
        repeat (3) step();

        // Reset with two held entries and stall_cnt at 7
        offer(0, 64'h11, 1'b1);
        step();
        offer(0, 64'h22, 1'b0);
        step();
        dv_in_valid[0] = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("mr_occ2", 0, 64'(w_occ[0]), 64'd2);
        check("mr_stall7", 0, 64'(w_stall[0]), 64'd7);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(0);
        @(negedge clk);
        check("mr_out_valid", 0, 64'(w_out_valid[0]), 64'd0);
        check("mr_occ0", 0, 64'(w_occ[0]), 64'd0);
        check("mr_stall0", 0, 64'(w_stall[0]), 64'd0);
        check("mr_in_ready", 0, 64'(w_in_ready[0]), 64'd1);
        check("mr_data0", 0, w_out_data[0], 64'd0);
        repeat (4) step();

        // Single-entry variant: combinational ready and accept+emit together
        offer(1, 64'h55, 1'b0);
        step();
        offer(1, 64'h66, 1'b0);
        @(negedge clk);
        check("s0_in_ready0", 1, 64'(w_in_ready[1]), 64'd0);
        check("s0_occ1", 1, 64'(w_occ[1]), 64'd1);
        step();
        dv_out_ready[1] = 1'b1;
        @(negedge clk);
        check("s0_in_ready1", 1, 64'(w_in_ready[1]), 64'd1);
        step();
        dv_in_valid[1]  = 1'b0;
        dv_out_ready[1] = 1'b0;
        @(negedge clk);
        check("s0_occ_pass", 1, 64'(w_occ[1]), 64'd1);
        check("s0_data_66", 1, w_out_data[1], 64'h66);

        // Saturation of the 4-bit counter over 20 back-pressured cycles
        repeat (20) step();
        @(negedge clk);
        check("sat_stall15", 1, 64'(w_stall[1]), 64'd15);
        check("sat_held", 1, 64'(w_out_valid[1]), 64'd1);
        step();
        idle(1);
        repeat (2) step();

        // Streaming 1..10 with out_ready held high on both instances
        for (int k = 1; k <= 10; k++) begin
            offer(0, 64'(k), 1'b1);
            offer(1, 64'(k), 1'b1);
            @(negedge clk);
            if (k > 1) begin
                for (int d = 0; d < 2; d++) begin
                    check("stream_data", d, w_out_data[d], 64'(k - 1));
                    check("stream_occ", d, 64'(w_occ[d]), 64'd1);
                end
            end
            step();
        end
        idle(0);
        idle(1);
        repeat (3) step();

        // Randomised traffic with flushes and occasional resets
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                acc[d] = dv_in_valid[d] && w_in_ready[d] && !reset;
            step();
            reset = ((i % 750) == 749);
            for (int d = 0; d < 2; d++) begin
                if (acc[d] || !dv_in_valid[d]) begin
                    dv_in_valid[d] = ($urandom_range(0, 3) != 0);
                    dv_in_data[d]  = {$urandom, $urandom};
                end else if ($urandom_range(0, 15) == 0) begin
                    dv_in_valid[d] = 1'b0;
                end
                dv_out_ready[d] = ($urandom_range(0, 2) != 0);
                dv_flush[d]     = ($urandom_range(0, 31) == 0);
            end
        end
        reset = 1'b0;
        idle(0);
        idle(1);
        repeat (6) step();
        do_final = 1'b1;
        @(negedge clk);
        step();
        do_final = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
